hwag_div_scheduler: RTL and testbench
=====================================

// Module: hwag_div_scheduler
// PURPOSE
//  Time-shares one iterative restoring divider between NREQ requesters (instant RPM, dwell angle, future calcs).
//  Replaces per-calc divider instances in the hwag top level.
//  Arbitrates, loads operands, sequences the divide, returns quotient/remainder with a per-requester done pulse.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (dividend, divider, quotient, remainder)
//  NREQ   2   number of requesters; index 0 = RPM calc, 1 = dwell calc
// PORTS
//  clk        in   1           system clock; all logic on rising edge
//  rst        in   1           asynchronous, active-high reset
//  req        in   NREQ        level request per requester; held until matching done bit
//  dividend   in   NREQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
//  divider    in   NREQ*WIDTH  packed divisors, same packing
//  done       out  NREQ        one-cycle pulse: result/remainder valid for that requester
//  result     out  WIDTH       quotient of last completed op; held until next completion
//  remainder  out  WIDTH       remainder of last completed op; held until next completion
//  div_zero   out  1           asserted with done when the divisor was 0
//  busy       out  1           high from grant cycle until done cycle inclusive
// BEHAVIOUR
//  Reset: state IDLE, done=0, result=0, remainder=0, div_zero=0, busy=0, rr pointer=0.
//  Reset mid-operation aborts it; no done pulse is ever issued for the aborted op.
//  FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//   IDLE: if any req, grant one (arbitration below), latch grant index and operands -> LOAD.
//   LOAD: init partial remainder=0, quotient=dividend, bit counter=WIDTH-1; busy=1.
//         divider==0 -> skip RUN, go to DONE with result='1, remainder=dividend, div_zero=1.
//   RUN: one restoring-division step per cycle; exits after WIDTH steps -> DONE.
//   DONE: register result/remainder; done[grant]=1 only if req[grant] still high; -> IDLE.
//  Latency: req sampled in IDLE at cycle 0 -> done at cycle WIDTH+2 (34 for WIDTH=32); div-by-zero at cycle 2.
//  Throughput: back-to-back ops, 1 IDLE cycle between them.
//  Operands are latched at grant; later operand changes do not affect the running op.
//  Arbitration: round-robin from rr pointer; after a grant, pointer = grant+1 mod NREQ.
//  Simultaneous reqs: lowest index at or above pointer wins. The loser waits at most one op.
//  req dropped during LOAD/RUN: op completes, result/remainder still update, done suppressed.
//  req re-asserted in DONE cycle after a suppressed done is a new request.
//  Requester must deassert req in the cycle after its done, otherwise it is re-queued.
//  Arithmetic: unsigned only; quotient truncates; remainder < divisor always.
// CONFIGURATION
//  Macro HWAG_DIV_SCHED_PRIO0_EN:
//   defined:   requester 0 has fixed top priority over round-robin;
//              other requesters stay round-robin among themselves; pointer skips index 0.
//   undefined: pure round-robin across all NREQ requesters.
// STRUCTURE
//  Shared package hwag_div_pkg:
//   - typedef enum {DS_IDLE, DS_LOAD, DS_RUN, DS_DONE} div_state_t
//   - localparam DIV_RPM_IDX=0, DIV_DWELL_IDX=1
//  Sub-module hwag_div_core: WIDTH-step restoring divider.
//   - start / step / fin interface; busy-free; step counter internal.
//  Scheduler file holds arbiter, operand mux/latch, FSM, output registers.
// TESTING
//  1 Single req[0], dividend=32'h2FAF080, divider=12500 -> done[0] at cycle 34; result=4000, remainder=0, div_zero=0.
//  2 req[1], dividend=50000, divider=3 -> done[1]; result=16666, remainder=2.
//  3 req[0], divider=0, dividend=7 -> done[0] at cycle 2; result=32'hFFFFFFFF, remainder=7, div_zero=1.
//  4 req=2'b11 from reset -> grant 0 first, then 1.
//    Repeat with pointer=1 -> grant 1 first.
//    With HWAG_DIV_SCHED_PRIO0_EN -> always 0 first.
//  5 req[1] dropped at RUN step 10 -> result/remainder update, done stays 0; queued req[0] is served next.
//  6 rst pulsed during RUN -> all outputs 0 next cycle, no done.
//    New req afterwards completes with correct values.

Source files
------------

// File: rtl/hwag_div_pkg.sv
// hwag_div_pkg: shared types and constants for the time-shared hwag divider.
// Contents: scheduler FSM state encoding and fixed requester indices.
// No ports; imported by hwag_div_core and hwag_div_scheduler.
package hwag_div_pkg;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_LOAD,
    DS_RUN,
    DS_DONE
  } div_state_t;

  // Requester slots on the scheduler's req/done vectors
  localparam int DIV_RPM_IDX   = 0;
  localparam int DIV_DWELL_IDX = 1;

endpackage

// File: rtl/hwag_div_core.sv
// hwag_div_core: WIDTH-step unsigned restoring divider, one quotient bit per step.
// Ports: clk/rst; start loads operands; step advances one bit; fin flags the last step;
//        step_quotient/step_remainder are the values the current step produces.
module hwag_div_core
  import hwag_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             fin,
  output logic [WIDTH-1:0] step_quotient,
  output logic [WIDTH-1:0] step_remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] prem;   // partial remainder
  logic [WIDTH-1:0] quo;    // dividend shifting out at the top, quotient shifting in below
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor,
  // keep the difference only when it did not go negative.
  always_comb begin
    shifted        = {prem, quo[WIDTH-1]};
    diff           = shifted - {1'b0, dsr};
    step_remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    step_quotient  = {quo[WIDTH-2:0], ~diff[WIDTH]};
    fin            = step && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prem <= '0;
      quo  <= '0;
      dsr  <= '0;
      cnt  <= '0;
    end else if (start) begin
      prem <= '0;
      quo  <= dividend;
      dsr  <= divisor;
      cnt  <= CW'(WIDTH - 1);
    end else if (step) begin
      prem <= step_remainder;
      quo  <= step_quotient;
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/hwag_div_scheduler.sv
// hwag_div_scheduler: shares one restoring divider between NREQ requesters.
// Ports: req/dividend/divider per requester (packed i*WIDTH); done one-hot pulse,
//        result/remainder held until next completion, div_zero with done, busy LOAD..DONE.
// Option: HWAG_DIV_SCHED_PRIO0_EN gives requester 0 fixed priority over the round-robin.
module hwag_div_scheduler
  import hwag_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dividend,
  input  logic [NREQ*WIDTH-1:0] divider,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      remainder,
  output logic                  div_zero,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef HWAG_DIV_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  // With requester 0 outside the rotation the pointer wraps to 1, not 0
  localparam logic [IW-1:0] RR_WRAP = PRIO0 ? IW'(1) : '0;

  div_state_t       state, state_nxt;
  logic [IW-1:0]    rr;
  logic [IW-1:0]    grant;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;
  logic             dz;
  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  int               cand;
  logic             core_fin;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;

  // Arbiter: scan the rotation starting at rr; iterating downwards lets the
  // first requester in rotation order overwrite the later ones.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand] && !(PRIO0 && cand == DIV_RPM_IDX)) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (PRIO0 && req[DIV_RPM_IDX]) begin
      gnt_vld = 1'b1;
      gnt_idx = IW'(DIV_RPM_IDX);
    end
  end

  hwag_div_core #(.WIDTH(WIDTH)) u_core (
    .clk            (clk),
    .rst            (rst),
    .start          (state == DS_LOAD),
    .step           (state == DS_RUN),
    .dividend       (op_dividend),
    .divisor        (op_divisor),
    .fin            (core_fin),
    .step_quotient  (core_q),
    .step_remainder (core_r)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DS_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (gnt_vld) state_nxt = DS_LOAD;
      DS_LOAD: state_nxt = (op_divisor == '0) ? DS_DONE : DS_RUN;
      DS_RUN:  if (core_fin) state_nxt = DS_DONE;
      DS_DONE: state_nxt = DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  // FSM outputs; done is dropped if the requester let go of req mid-op
  always_comb begin
    done        = '0;
    if (state == DS_DONE) done[grant] = req[grant];
    busy        = (state != DS_IDLE);
    div_zero    = (state == DS_DONE) && dz;
  end

  // Grant/operand latch, rr pointer and result registers. Results load on the
  // edge into DONE so they are already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr          <= '0;
      grant       <= '0;
      op_dividend <= '0;
      op_divisor  <= '0;
      result      <= '0;
      remainder   <= '0;
      dz          <= 1'b0;
    end else begin
      if (state == DS_IDLE && gnt_vld) begin
        grant       <= gnt_idx;
        op_dividend <= dividend[gnt_idx*WIDTH +: WIDTH];
        op_divisor  <= divider[gnt_idx*WIDTH +: WIDTH];
        if (!(PRIO0 && gnt_idx == IW'(DIV_RPM_IDX))) begin
          if (gnt_idx == IW'(NREQ - 1)) rr <= RR_WRAP;
          else                          rr <= gnt_idx + IW'(1);
        end
      end
      if (state == DS_LOAD && op_divisor == '0) begin
        result    <= '1;
        remainder <= op_dividend;
        dz        <= 1'b1;
      end
      if (state == DS_RUN && core_fin) begin
        result    <= core_q;
        remainder <= core_r;
        dz        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hwag_div_scheduler.sv
// tb_hwag_div_scheduler: directed bench for the shared divider scheduler.
// Table of single-requester divides plus sequences for arbitration,
// dropped requests and reset during an operation.
module tb_hwag_div_scheduler;
  import hwag_div_pkg::*;

  localparam int W = 32;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] dividend = '0;
  logic [N*W-1:0] divider = '0;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hwag_div_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dividend  (dividend),
    .divider   (divider),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Returns at the first negedge where done is non-zero; cyc = -1 on timeout.
  task automatic wait_done(input int from, output logic [N-1:0] d, output int cyc,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
    int c;
    d = '0; cyc = -1; q = '0; r = '0; z = 1'b0;
    c = from;
    while (cyc < 0 && c <= from + 80) begin
      @(negedge clk);
      if (done != '0) begin
        d = done; cyc = c; q = result; r = remainder; z = div_zero;
      end
      c++;
    end
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    dividend[idx*W +: W] = a;
    divider[idx*W +: W]  = b;
  endtask

  vec_t        vecs[10];
  logic [N-1:0] d;
  int          cyc;
  logic [31:0] q, r;
  logic        z;
  int          seen;
  int          first_b;

  initial begin
    vecs[0] = '{0, 32'h02FAF080, 32'd12500,      32'd4000,     32'd0,    1'b0, 34};
    vecs[1] = '{1, 32'd50000,    32'd3,          32'd16666,    32'd2,    1'b0, 34};
    vecs[2] = '{0, 32'd7,        32'd0,          32'hFFFFFFFF, 32'd7,    1'b1, 2};
    vecs[3] = '{1, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF, 32'd0,    1'b0, 34};
    vecs[4] = '{0, 32'd100,      32'd7,          32'd14,       32'd2,    1'b0, 34};
    vecs[5] = '{1, 32'd5,        32'd9,          32'd0,        32'd5,    1'b0, 34};
    vecs[6] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'd1,        32'd0,    1'b0, 34};
    vecs[7] = '{1, 32'd0,        32'd0,          32'hFFFFFFFF, 32'd0,    1'b1, 2};
    vecs[8] = '{0, 32'h80000000, 32'h10,         32'h08000000, 32'd0,    1'b0, 34};
    vecs[9] = '{1, 32'd1000003,  32'd1000,       32'd1000,     32'd3,    1'b0, 34};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: one requester at a time, cycle 0 = negedge where req is raised
    for (int i = 0; i < 10; i++) begin
      req = '0; dividend = '0; divider = '0;
      set_op(vecs[i].idx, vecs[i].a, vecs[i].b);
      req[vecs[i].idx] = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_busy_load", i), 32'(busy), 32'd1);
      wait_done(2, d, cyc, q, r, z);
      req = '0;
      check($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      check($sformatf("v%0d_done", i), 32'(d), 32'(1) << vecs[i].idx);
      check($sformatf("v%0d_result", i), q, vecs[i].q);
      check($sformatf("v%0d_remainder", i), r, vecs[i].r);
      check($sformatf("v%0d_div_zero", i), 32'(z), 32'(vecs[i].z));
      @(negedge clk);
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // Simultaneous requests from reset: 0 first, then 1 after one IDLE cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_op(0, 32'd20, 32'd4);
    set_op(1, 32'd21, 32'd5);
    req = 2'b11;
    wait_done(1, d, cyc, q, r, z);
    req[0] = 1'b0;
    check("arb_first_done", 32'(d), 32'd1);
    check("arb_first_cycle", cyc, 34);
    check("arb_first_result", q, 32'd5);
    wait_done(35, d, cyc, q, r, z);
    req = '0;
    check("arb_second_done", 32'(d), 32'd2);
    check("arb_second_cycle", cyc, 69);
    check("arb_second_result", q, 32'd4);
    check("arb_second_remainder", r, 32'd1);
    @(negedge clk);

    // Move the pointer to 1 with a lone requester-0 op, then contend again
    set_op(0, 32'd9, 32'd2);
    req = 2'b01;
    wait_done(1, d, cyc, q, r, z);
    req = '0;
    check("rr_prep_result", q, 32'd4);
    @(negedge clk);
`ifdef HWAG_DIV_SCHED_PRIO0_EN
    first_b = DIV_RPM_IDX;
`else
    first_b = DIV_DWELL_IDX;
`endif
    set_op(0, 32'd40, 32'd6);
    set_op(1, 32'd41, 32'd8);
    req = 2'b11;
    wait_done(1, d, cyc, q, r, z);
    check("rr_ptr1_first", 32'(d), 32'(1) << first_b);
    check("rr_ptr1_first_q", q, (first_b == 0) ? 32'd6 : 32'd5);
    req[first_b] = 1'b0;
    wait_done(35, d, cyc, q, r, z);
    req = '0;
    check("rr_ptr1_second", 32'(d), 32'(1) << (1 - first_b));
    check("rr_ptr1_second_r", r, (first_b == 0) ? 32'd1 : 32'd4);
    @(negedge clk);

    // Requester 1 drops req at RUN step 10; requester 0 queued behind it
    seen = 0;
    set_op(1, 32'd1000, 32'd7);
    req = 2'b10;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (done != '0) seen++;
      if (c == 1) begin
        set_op(0, 32'd30, 32'd4);
        req[0] = 1'b1;
      end
      if (c == 11) req[1] = 1'b0;
      if (c == 34) begin
        check("drop_result", result, 32'd142);
        check("drop_remainder", remainder, 32'd6);
      end
    end
    check("drop_no_done", seen, 0);
    wait_done(35, d, cyc, q, r, z);
    req = '0;
    check("drop_next_done", 32'(d), 32'd1);
    check("drop_next_cycle", cyc, 69);
    check("drop_next_result", q, 32'd7);
    check("drop_next_remainder", r, 32'd2);
    @(negedge clk);

    // Reset during RUN aborts the op with no done
    set_op(0, 32'h02FAF080, 32'd12500);
    req = 2'b01;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_div_zero", 32'(div_zero), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    check("midrst_no_done", seen, 0);
    set_op(1, 32'd50000, 32'd3);
    req = 2'b10;
    wait_done(1, d, cyc, q, r, z);
    req = '0;
    check("postrst_done", 32'(d), 32'd2);
    check("postrst_cycle", cyc, 34);
    check("postrst_result", q, 32'd16666);
    check("postrst_remainder", r, 32'd2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
